// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two-requester round-robin burst arbiter driving a registered
// register-file write port, with per-requester accepted-beat counters.
module regfile_write_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [2:0] a_addr,
    input  logic [7:0] a_data,
    input  logic       a_last,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [2:0] b_addr,
    input  logic [7:0] b_data,
    input  logic       b_last,
    output logic       b_ready,
    output logic       rf_we,
    output logic [2:0] rf_waddr,
    output logic [7:0] rf_wdata,
    output logic [1:0] owner,
    output logic [7:0] a_beats,
    output logic [7:0] b_beats
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] OWN_A = 2'b01;
    localparam logic [1:0] OWN_B = 2'b10;

    logic [1:0] state, next;
    logic       rr_b;
    logic [3:0] cnt;
    logic       acc_a, acc_b, acc, rel;

    assign acc_a = a_valid && a_ready;
    assign acc_b = b_valid && b_ready;
    assign acc   = acc_a || acc_b;
    assign rel   = acc && ((acc_a ? a_last : b_last) || (cnt + 4'd1 == 4'(MAX_BURST)));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        if (state == IDLE)
            next = (a_valid && b_valid) ? (rr_b ? OWN_B : OWN_A) :
                   a_valid ? OWN_A : b_valid ? OWN_B : IDLE;
        else if (rel)
            next = (state == OWN_A) ? (b_valid ? OWN_B : IDLE) : (a_valid ? OWN_A : IDLE);
    end

    always_comb begin
        a_ready = (state == OWN_A);
        b_ready = (state == OWN_B);
        owner   = state;
    end

    // rr_b set means B is favoured on the next contested grant from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_b     <= 1'b0;
            cnt      <= 4'd0;
            rf_we    <= 1'b0;
            rf_waddr <= 3'd0;
            rf_wdata <= 8'd0;
            a_beats  <= 8'd0;
            b_beats  <= 8'd0;
        end else begin
            if (rel) rr_b <= (state == OWN_A);
            cnt   <= (next != state) ? 4'd0 : acc ? cnt + 4'd1 : cnt;
            rf_we <= acc;
            if (acc) begin
                rf_waddr <= acc_a ? a_addr : b_addr;
                rf_wdata <= acc_a ? a_data : b_data;
            end
            if (acc_a) a_beats <= a_beats + 8'd1;
            if (acc_b) b_beats <= b_beats + 8'd1;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed self-checking bench for regfile_write_arbiter
// with MAX_BURST=4; inputs change and outputs are sampled 1ns after each rising edge.
module tb_regfile_write_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [2:0] a_addr = 3'd0, b_addr = 3'd0;
    logic [7:0] a_data = 8'd0, b_data = 8'd0;
    logic       a_last = 1'b0, b_last = 1'b0;
    logic       a_ready, b_ready, rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata, a_beats, b_beats;
    logic [1:0] owner;
    int         checks = 0;
    int         failures = 0;

    regfile_write_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .owner(owner),
        .a_beats(a_beats), .b_beats(b_beats)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [2:0] ad, input logic [7:0] d);
        chk({tag, "_we"}, 32'(rf_we), 32'(we));
        chk({tag, "_addr"}, 32'(rf_waddr), 32'(ad));
        chk({tag, "_data"}, 32'(rf_wdata), 32'(d));
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_a_beats", 32'(a_beats), 32'd0);
        chk("rst_b_beats", 32'(b_beats), 32'd0);
        chk_rf("rst_rf", 1'b0, 3'd0, 8'h00);

        // single beat from A
        a_valid = 1'b1; a_addr = 3'd3; a_data = 8'h5A; a_last = 1'b1;
        step();
        chk("single_owner_grant", 32'(owner), 32'd1);
        chk("single_a_ready", 32'(a_ready), 32'd1);
        chk("single_no_write_yet", 32'(rf_we), 32'd0);
        step();
        chk("single_owner_released", 32'(owner), 32'd0);
        chk_rf("single_rf", 1'b1, 3'd3, 8'h5A);
        chk("single_a_beats", 32'(a_beats), 32'd1);
        a_valid = 1'b0;
        step();
        chk_rf("single_rf_hold", 1'b0, 3'd3, 8'h5A);

        // reset, then both requesters contend with single-beat bursts
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_a_beats", 32'(a_beats), 32'd0);
        a_valid = 1'b1; a_addr = 3'd1; a_data = 8'h11; a_last = 1'b1;
        b_valid = 1'b1; b_addr = 3'd2; b_data = 8'h22; b_last = 1'b1;
        step();
        chk("rr_first_grant_a", 32'(owner), 32'd1);
        chk("rr_first_no_write", 32'(rf_we), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_owner", 32'(owner), (i % 2 == 0) ? 32'd2 : 32'd1);
            chk_rf("rr_rf", 1'b1, (i % 2 == 0) ? 3'd1 : 3'd2, (i % 2 == 0) ? 8'h11 : 8'h22);
        end

        // A still owns the grant; with no valid it must hold indefinitely
        a_valid = 1'b0; b_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_owner", 32'(owner), 32'd1);
            chk("hold_a_ready", 32'(a_ready), 32'd1);
            chk("hold_rf_we", 32'(rf_we), 32'd0);
        end

        // A streams without last, B waits: A limited to 4 beats, B takes over with no gap
        a_valid = 1'b1; a_last = 1'b0; a_addr = 3'd4;
        b_valid = 1'b1; b_last = 1'b1; b_addr = 3'd5; b_data = 8'hB1;
        for (int i = 0; i < 4; i++) begin
            a_data = 8'hA0 + 8'(i);
            step();
            chk("burst_owner", 32'(owner), (i < 3) ? 32'd1 : 32'd2);
            chk_rf("burst_rf", 1'b1, 3'd4, 8'hA0 + 8'(i));
        end
        a_data = 8'hA4;
        step();
        chk("burst_b_owner_back_to_a", 32'(owner), 32'd1);
        chk_rf("burst_b_rf", 1'b1, 3'd5, 8'hB1);
        b_valid = 1'b0;
        step();
        chk("burst_resume_owner", 32'(owner), 32'd1);
        chk_rf("burst_resume_rf", 1'b1, 3'd4, 8'hA4);
        a_data = 8'hA5; a_last = 1'b1;
        step();
        chk("burst_end_owner", 32'(owner), 32'd0);
        chk_rf("burst_end_rf", 1'b1, 3'd4, 8'hA5);
        chk("burst_a_beats", 32'(a_beats), 32'd8);
        chk("burst_b_beats", 32'(b_beats), 32'd3);
        a_valid = 1'b0;

        // reset lands on an accept edge: that beat is dropped
        a_valid = 1'b1; a_last = 1'b0; a_addr = 3'd7; a_data = 8'hC3;
        step();
        step();
        chk_rf("pre_rst_rf", 1'b1, 3'd7, 8'hC3);
        a_data = 8'hC4; rst = 1'b1;
        step();
        chk("midrst_owner", 32'(owner), 32'd0);
        chk_rf("midrst_rf", 1'b0, 3'd0, 8'h00);
        chk("midrst_a_beats", 32'(a_beats), 32'd0);
        chk("midrst_b_beats", 32'(b_beats), 32'd0);
        rst = 1'b0;

        // 64 bursts of 4 beats, 5 cycles each: 256 beats wraps a_beats
        a_valid = 1'b1; a_last = 1'b0; a_addr = 3'd6; a_data = 8'h77;
        repeat (319) step();
        chk("wrap_a_beats_255", 32'(a_beats), 32'd255);
        step();
        chk("wrap_a_beats_0", 32'(a_beats), 32'd0);
        chk("wrap_owner", 32'(owner), 32'd0);
        chk("wrap_b_beats", 32'(b_beats), 32'd0);
        a_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
